// File: rtl/regwb_arbiter.sv
// Round-robin arbiter that merges NREQ writeback producers onto one registered
// regfile write port, with per-producer FIFOs and a pending-write scoreboard.
module regwb_arbiter #(
    parameter int NREQ       = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][37:0]     req_wb,
    output logic [37:0]               wb_out,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic [31:0]               busy_regs
);
    localparam int IW = $clog2(NREQ);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // Queued entries drop the enable bit: only enabled writes are stored.
    logic [NREQ-1:0][36:0] heads;
    logic [NREQ-1:0][31:0] lane_busy;
    logic [NREQ-1:0]       nonempty;
    logic [IW-1:0]         last_grant;
    logic [IW-1:0]         winner;
    logic                  found;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        logic [36:0]   mem [FIFO_DEPTH];
        logic [AW-1:0] rd_ptr;
        logic [AW-1:0] wr_ptr;
        logic [CW-1:0] cnt;
        logic [AW-1:0] offs;
        logic [31:0]   busy;
        logic          enq;
        logic          deq;

        assign req_ready[i] = (cnt != CW'(FIFO_DEPTH));
        assign enq = req_valid[i] & req_ready[i] & req_wb[i][32]
                   & (req_wb[i][37:33] != 5'd0);
        assign deq = found && (winner == IW'(i));
        assign nonempty[i]  = (cnt != '0);
        assign heads[i]     = mem[rd_ptr];
        assign lane_busy[i] = busy;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + 1'b1;
                if (deq) rd_ptr <= rd_ptr + 1'b1;
                cnt <= cnt + CW'(enq) - CW'(deq);
            end
        end

        always_ff @(posedge clk) begin
            if (enq) mem[wr_ptr] <= {req_wb[i][37:33], req_wb[i][31:0]};
        end

        // An entry is live when its distance from the read pointer is below count.
        always_comb begin
            busy = '0;
            offs = '0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                offs = AW'(k) - rd_ptr;
                if ({1'b0, offs} < cnt) busy[mem[k][36:32]] = 1'b1;
            end
        end
    end

    always_comb begin
        int idx;
        found  = 1'b0;
        winner = last_grant;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && nonempty[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_out     <= '0;
            grant_id   <= '0;
            last_grant <= IW'(NREQ - 1);
        end else if (found) begin
            wb_out     <= {heads[winner][36:32], 1'b1, heads[winner][31:0]};
            grant_id   <= winner;
            last_grant <= winner;
        end else begin
            wb_out[32] <= 1'b0;
        end
    end

    always_comb begin
        busy_regs = '0;
        for (int i = 0; i < NREQ; i++) busy_regs = busy_regs | lane_busy[i];
        if (wb_out[32]) busy_regs[wb_out[37:33]] = 1'b1;
        busy_regs[0] = 1'b0;
    end
endmodule

// File: tb/tb_regwb_arbiter.sv
// Scoreboard bench for regwb_arbiter: per-producer expected queues filled on
// handshake, drained and compared whenever wb_out carries an enabled write.
module tb_regwb_arbiter;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][37:0] req_wb;
    logic [37:0]      wb_out;
    logic [0:0]       grant_id;
    logic [31:0]      busy_regs;

    int n_cmp = 0;
    int n_bad = 0;
    logic [36:0] sb0[$];
    logic [36:0] sb1[$];
    logic [4:0]  seen[$];
    logic [1:0]  acc;

    regwb_arbiter #(.NREQ(2), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wb(req_wb), .wb_out(wb_out), .grant_id(grant_id), .busy_regs(busy_regs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [37:0] rec(input logic [4:0] a, input logic we, input logic [31:0] d);
        return {a, we, d};
    endfunction

    // Called just after a negedge; the handshake lands on the coming posedge.
    task automatic step(output logic [1:0] a);
        a = req_valid & req_ready & {2{rst_n}};
        if (a[0] && req_wb[0][32] && req_wb[0][37:33] != 5'd0)
            sb0.push_back({req_wb[0][37:33], req_wb[0][31:0]});
        if (a[1] && req_wb[1][32] && req_wb[1][37:33] != 5'd0)
            sb1.push_back({req_wb[1][37:33], req_wb[1][31:0]});
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_out[32]) begin
            seen.push_back(wb_out[37:33]);
            if (grant_id == 1'b0) begin
                if (sb0.size() == 0) check("unexpected_wb_p0", wb_out, 0);
                else check("wb_p0", {wb_out[37:33], wb_out[31:0]}, sb0.pop_front());
            end else begin
                if (sb1.size() == 0) check("unexpected_wb_p1", wb_out, 0);
                else check("wb_p1", {wb_out[37:33], wb_out[31:0]}, sb1.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int i0;
        int i1;
        bit got;
        int tries;

        // T1: reset with all valids high, then idle after release
        rst_n = 1'b0;
        req_valid = 2'b11;
        req_wb[0] = rec(5'd3, 1'b1, 32'h1);
        req_wb[1] = rec(5'd4, 1'b1, 32'h2);
        repeat (3) @(negedge clk);
        check("t1_ready", req_ready, 2'b11);
        check("t1_wb", wb_out, 0);
        check("t1_busy", busy_regs, 0);
        check("t1_gid", grant_id, 0);
        #1;
        req_valid = '0;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t1_idle_wb", wb_out, 0);
            check("t1_idle_busy", busy_regs, 0);
        end

        // T2: single record latency
        #1;
        req_valid = 2'b01;
        req_wb[0] = rec(5'd5, 1'b1, 32'hDEAD);
        step(acc);
        check("t2_acc", acc, 2'b01);
        check("t2_busy_n1", busy_regs, 32'h20);
        check("t2_en_n1", wb_out[32], 0);
        #1;
        req_valid = '0;
        step(acc);
        check("t2_wb_n2", wb_out, rec(5'd5, 1'b1, 32'hDEAD));
        check("t2_gid_n2", grant_id, 0);
        check("t2_busy_n2", busy_regs, 32'h20);
        #1;
        step(acc);
        check("t2_en_n3", wb_out[32], 0);
        check("t2_busy_n3", busy_regs, 0);

        // T3: both producers saturating, order must alternate
        do_reset();
        seen.delete();
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 40 && (i0 < 4 || i1 < 4); c++) begin
            #1;
            req_valid = {i1 < 4, i0 < 4};
            req_wb[0] = rec(5'(1 + i0), 1'b1, 32'(32'h100 + i0));
            req_wb[1] = rec(5'(11 + i1), 1'b1, 32'(32'h200 + i1));
            step(acc);
            if (acc[0]) i0++;
            if (acc[1]) i1++;
        end
        #1;
        req_valid = '0;
        repeat (6) @(negedge clk);
        check("t3_pushed", {i0[7:0], i1[7:0]}, {8'd4, 8'd4});
        check("t3_count", seen.size(), 8);
        for (int k = 0; k < 8 && k < seen.size(); k++)
            check("t3_order", seen[k], (k % 2 == 0) ? (1 + k / 2) : (11 + k / 2));

        // T4: p1 fills while p0 competes; held record waits, none lost
        do_reset();
        #1;
        req_valid = 2'b11;
        req_wb[0] = rec(5'd21, 1'b1, 32'hA0);
        req_wb[1] = rec(5'd25, 1'b1, 32'hB0);
        step(acc);
        check("t4_acc1", acc, 2'b11);
        #1;
        req_wb[0] = rec(5'd22, 1'b1, 32'hA1);
        req_wb[1] = rec(5'd26, 1'b1, 32'hB1);
        step(acc);
        check("t4_acc2", acc, 2'b11);
        check("t4_ready_full", req_ready, 2'b01);
        check("t4_busy", busy_regs, (32'h1 << 21) | (32'h1 << 22) | (32'h1 << 25) | (32'h1 << 26));
        #1;
        req_valid = 2'b10;
        req_wb[1] = rec(5'd27, 1'b1, 32'hB2);
        step(acc);
        check("t4_no_passthru", acc[1], 0);
        got = 1'b0;
        tries = 0;
        for (int c = 0; c < 5 && !got; c++) begin
            #1;
            step(acc);
            got = acc[1];
            tries++;
        end
        check("t4_accepted", got, 1);
        check("t4_tries", tries, 1);
        #1;
        req_valid = '0;
        repeat (6) @(negedge clk);
        check("t4_sb0_empty", sb0.size(), 0);
        check("t4_sb1_empty", sb1.size(), 0);

        // T5: x0 and disabled records are accepted and dropped
        #1;
        req_valid = 2'b11;
        req_wb[0] = rec(5'd0, 1'b1, 32'h7);
        req_wb[1] = rec(5'd9, 1'b0, 32'h7);
        step(acc);
        check("t5_acc", acc, 2'b11);
        #1;
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            check("t5_busy", busy_regs, 0);
            check("t5_en", wb_out[32], 0);
            @(negedge clk);
        end

        // T6: async reset between edges discards everything
        do_reset();
        #1;
        req_valid = 2'b11;
        req_wb[0] = rec(5'd3, 1'b1, 32'hC0);
        req_wb[1] = rec(5'd13, 1'b1, 32'hD0);
        step(acc);
        #1;
        req_wb[0] = rec(5'd4, 1'b1, 32'hC1);
        req_wb[1] = rec(5'd14, 1'b1, 32'hD1);
        step(acc);
        check("t6_pre_en", wb_out[32], 1);
        #1;
        req_valid = '0;
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_en", wb_out[32], 0);
        check("t6_busy", busy_regs, 0);
        check("t6_ready", req_ready, 2'b11);
        sb0.delete();
        sb1.delete();
        seen.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_no_stale", seen.size(), 0);
        check("t6_busy_after", busy_regs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
